etx_arbiter: RTL and testbench

Transmit-side arbiter for the elink. Shares the single TX serializer path between three emesh packet sources: read responses returning to the Epiphany (rr), host-originated writes (wr) and host-originated read requests (rd). Applies the link's write/read pushback, inserts the configured ctrlmode, and registers the winning packet into a one-deep output stage that feeds the TX FIFO/serializer. Sits between the AXI slave/master protocol converters and the TX datapath.

---
 rtl/etx_arbiter.sv | 111 +++++++++++
 tb/tb_etx_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/etx_arbiter.sv
// Elink TX arbiter: grants one of rr/wr/rd per cycle into a one-deep registered output stage.
// Optional wr/rd round-robin fairness is enabled by defining ETX_ARB_ROUNDROBIN_EN.
module etx_arbiter #(
    parameter int PW = 103
) (
    input  logic          m_axi_aclk,
    input  logic          m_axi_aresetn,
    input  logic          ecfg_elink_en,
    input  logic [3:0]    ecfg_ctrlmode,
    input  logic          wr_wait,
    input  logic          rd_wait,
    input  logic          rr_req,
    input  logic          wr_req,
    input  logic          rd_req,
    input  logic [PW-1:0] rr_packet,
    input  logic [PW-1:0] wr_packet,
    input  logic [PW-1:0] rd_packet,
    output logic          rr_gnt,
    output logic          wr_gnt,
    output logic          rd_gnt,
    output logic          tx_access,
    output logic [PW-1:0] tx_packet,
    input  logic          tx_wait
);

    localparam int CTRL_LSB = PW - 7;

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_RR   = 2'd1;
    localparam logic [1:0] SRC_WR   = 2'd2;
    localparam logic [1:0] SRC_RD   = 2'd3;

    logic          cap;
    logic          rr_elig;
    logic          wr_elig;
    logic          rd_elig;
    logic [1:0]    sel;
    logic [PW-1:0] next_packet;

    // Output stage can accept when empty or being drained this cycle.
    assign cap     = !tx_access || !tx_wait;
    assign rr_elig = ecfg_elink_en && rr_req && !wr_wait;
    assign wr_elig = ecfg_elink_en && wr_req && !wr_wait;
    assign rd_elig = ecfg_elink_en && rd_req && !rd_wait;

`ifdef ETX_ARB_ROUNDROBIN_EN
    logic last;  // 0 = wr served last, 1 = rd served last

    always_comb begin
        // NOTE: default assignment first so every path drives sel and no latch is inferred.
        sel = SRC_NONE;
        if (cap) begin
            if (rr_elig)                 sel = SRC_RR;
            else if (wr_elig && rd_elig) sel = last ? SRC_WR : SRC_RD;
            else if (wr_elig)            sel = SRC_WR;
            else if (rd_elig)            sel = SRC_RD;
        end
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            last <= 1'b1;
        end else if (sel == SRC_WR) begin
            last <= 1'b0;
        end else if (sel == SRC_RD) begin
            last <= 1'b1;
        end
    end
`else
    always_comb begin
        sel = SRC_NONE;
        if (cap) begin
            if (rr_elig)      sel = SRC_RR;
            else if (wr_elig) sel = SRC_WR;
            else if (rd_elig) sel = SRC_RD;
        end
    end
`endif

    // Grants are suppressed while reset is held, even though the stage looks empty.
    assign rr_gnt = m_axi_aresetn && (sel == SRC_RR);
    assign wr_gnt = m_axi_aresetn && (sel == SRC_WR);
    assign rd_gnt = m_axi_aresetn && (sel == SRC_RD);

    always_comb begin
        next_packet = rr_packet;
        case (sel)
            SRC_WR:  next_packet = wr_packet;
            SRC_RD:  next_packet = rd_packet;
            default: next_packet = rr_packet;
        endcase
        // Host-originated traffic carries the configured ctrlmode; read responses pass untouched.
        if (sel == SRC_WR || sel == SRC_RD) begin
            next_packet[CTRL_LSB +: 4] = ecfg_ctrlmode;
        end
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            // NOTE: non-blocking assignments for all sequential state avoid simulation races.
            tx_access <= 1'b0;
            tx_packet <= '0;
        end else if (cap) begin
            tx_access <= (sel != SRC_NONE);
            if (sel != SRC_NONE) begin
                tx_packet <= next_packet;
            end
        end
    end

endmodule

// File: tb/tb_etx_arbiter.sv
// Self-checking bench for etx_arbiter: directed scenarios plus random traffic,
// grants checked immediately and output stage checked through a scoreboard queue.
module tb_etx_arbiter;

    localparam int PW = 103;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          elink_en;
    logic [3:0]    ctrlmode;
    logic          wr_wait;
    logic          rd_wait;
    logic          tx_wait;
    logic          req [3];
    logic [PW-1:0] pkt [3];
    logic          rr_gnt;
    logic          wr_gnt;
    logic          rd_gnt;
    logic          tx_access;
    logic [PW-1:0] tx_packet;

    always #5 clk = ~clk;

    etx_arbiter #(.PW(PW)) dut (
        .m_axi_aclk    (clk),
        .m_axi_aresetn (rst_n),
        .ecfg_elink_en (elink_en),
        .ecfg_ctrlmode (ctrlmode),
        .wr_wait       (wr_wait),
        .rd_wait       (rd_wait),
        .rr_req        (req[0]),
        .wr_req        (req[1]),
        .rd_req        (req[2]),
        .rr_packet     (pkt[0]),
        .wr_packet     (pkt[1]),
        .rd_packet     (pkt[2]),
        .rr_gnt        (rr_gnt),
        .wr_gnt        (wr_gnt),
        .rd_gnt        (rd_gnt),
        .tx_access     (tx_access),
        .tx_packet     (tx_packet),
        .tx_wait       (tx_wait)
    );

    typedef struct {
        logic          access;
        logic [PW-1:0] packet;
    } out_t;

    out_t          sb_q[$];
    out_t          mon_e;
    int            n_tests = 0;
    int            n_fail = 0;
    int            dut_cnt [3];
    int            last_win = -1;
    logic [PW-1:0] saved;

    // Reference model state: what the output stage holds and who was served last.
    bit            m_access;
    logic [PW-1:0] m_packet;
    bit            m_last;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] rand_pkt();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        return t[PW-1:0];
    endfunction

    task automatic model_reset();
        m_access = 1'b0;
        m_packet = '0;
        m_last   = 1'b1;
        last_win = -1;
    endtask

    // Called at a negedge with inputs applied; returns at the following negedge.
    task automatic step();
        bit            elig [3];
        bit            cap;
        int            win;
        logic [PW-1:0] p;
        out_t          e;
        #1;
        cap     = !m_access || !tx_wait;
        elig[0] = elink_en && req[0] && !wr_wait;
        elig[1] = elink_en && req[1] && !wr_wait;
        elig[2] = elink_en && req[2] && !rd_wait;
        win = -1;
        if (cap) begin
            if (elig[0]) win = 0;
            else if (elig[1] && elig[2]) begin
`ifdef ETX_ARB_ROUNDROBIN_EN
                win = m_last ? 1 : 2;
`else
                win = 1;
`endif
            end
            else if (elig[1]) win = 1;
            else if (elig[2]) win = 2;
        end
        check("gnt", PW'({rr_gnt, wr_gnt, rd_gnt}), PW'({win == 0, win == 1, win == 2}));
        dut_cnt[0] += int'(rr_gnt);
        dut_cnt[1] += int'(wr_gnt);
        dut_cnt[2] += int'(rd_gnt);
        if (cap) begin
            m_access = (win >= 0);
            if (win >= 0) begin
                p = pkt[win];
                if (win != 0) p[99:96] = ctrlmode;
                m_packet = p;
                if (win == 1) m_last = 1'b0;
                if (win == 2) m_last = 1'b1;
            end
        end
        e.access = m_access;
        e.packet = m_packet;
        sb_q.push_back(e);
        last_win = win;
        @(posedge clk);
        @(negedge clk);
    endtask

    // A granted source presents its next packet.
    task automatic refresh();
        if (last_win >= 0) pkt[last_win] = rand_pkt();
    endtask

    task automatic clear_cnt();
        for (int i = 0; i < 3; i++) dut_cnt[i] = 0;
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < 3; i++) begin
            if (last_win == i || !req[i]) begin
                req[i] = ($urandom_range(2) != 0);
                pkt[i] = rand_pkt();
            end else if ($urandom_range(9) == 0) begin
                req[i] = 1'b0;
            end
        end
        elink_en = ($urandom_range(9) != 0);
        ctrlmode = 4'($urandom());
        wr_wait  = ($urandom_range(4) == 0);
        rd_wait  = ($urandom_range(4) == 0);
        tx_wait  = ($urandom_range(9) < 3);
    endtask

    // Monitor: pops the expected output-stage state after every clock edge.
    always begin
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("tx_access", PW'(tx_access), PW'(mon_e.access));
            check("tx_packet", tx_packet, mon_e.packet);
        end
    end

    initial begin
        elink_en = 1'b1;
        ctrlmode = 4'h0;
        wr_wait  = 1'b0;
        rd_wait  = 1'b0;
        tx_wait  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b1;
            pkt[i] = rand_pkt();
        end
        model_reset();
        clear_cnt();

        // Reset with all requests high.
        repeat (2) @(negedge clk);
        #1;
        check("rst_gnt", PW'({rr_gnt, wr_gnt, rd_gnt}), '0);
        check("rst_tx_access", PW'(tx_access), '0);
        check("rst_tx_packet", tx_packet, '0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("first_rr_gnt", PW'(dut_cnt[0]), PW'(1));
        refresh();

        // wr/rd contention.
        req[0] = 1'b0;
        clear_cnt();
        repeat (6) begin
            step();
            refresh();
        end
`ifdef ETX_ARB_ROUNDROBIN_EN
        check("contention_wr", PW'(dut_cnt[1]), PW'(3));
        check("contention_rd", PW'(dut_cnt[2]), PW'(3));
`else
        check("contention_wr", PW'(dut_cnt[1]), PW'(6));
        check("contention_rd", PW'(dut_cnt[2]), PW'(0));
`endif

        // rr always wins.
        req[0] = 1'b1;
        clear_cnt();
        repeat (3) begin
            step();
            refresh();
        end
        check("rr_priority", PW'(dut_cnt[0]), PW'(3));

        // Pushback.
        wr_wait = 1'b1;
        clear_cnt();
        step();
        refresh();
        check("wr_wait_gnts", PW'({dut_cnt[0][1:0], dut_cnt[1][1:0], dut_cnt[2][1:0]}), PW'(6'b000001));
        rd_wait = 1'b1;
        clear_cnt();
        step();
        step();
        check("all_wait_gnts", PW'(dut_cnt[0] + dut_cnt[1] + dut_cnt[2]), '0);
        check("all_wait_drained", PW'(tx_access), '0);
        wr_wait = 1'b0;
        rd_wait = 1'b0;

        // Output stall with a waiting write.
        req[0] = 1'b0;
        req[2] = 1'b0;
        step();
        refresh();
        saved   = tx_packet;
        tx_wait = 1'b1;
        clear_cnt();
        repeat (3) begin
            step();
            check("stall_hold", tx_packet, saved);
        end
        check("stall_gnts", PW'(dut_cnt[0] + dut_cnt[1] + dut_cnt[2]), '0);
        tx_wait = 1'b0;
        clear_cnt();
        saved = pkt[1];
        saved[99:96] = 4'h0;
        step();
        check("stall_release_gnt", PW'(dut_cnt[1]), PW'(1));
        check("stall_release_pkt", tx_packet, saved);

        // ctrlmode insertion.
        ctrlmode = 4'hA;
        pkt[1][99:96] = 4'h0;
        step();
        check("ctrl_wr", PW'(tx_packet[99:96]), PW'(4'hA));
        req[1] = 1'b0;
        req[0] = 1'b1;
        pkt[0][99:96] = 4'h3;
        step();
        check("ctrl_rr", PW'(tx_packet[99:96]), PW'(4'h3));
        refresh();

        // Random traffic with a reset in the middle.
        for (int c = 0; c < 400; c++) begin
            if (c == 200) begin
                for (int i = 0; i < 3; i++) req[i] = 1'b1;
                tx_wait = 1'b1;
                rst_n   = 1'b0;
                #1;
                check("midrst_gnt", PW'({rr_gnt, wr_gnt, rd_gnt}), '0);
                check("midrst_tx_access", PW'(tx_access), '0);
                check("midrst_tx_packet", tx_packet, '0);
                sb_q.delete();
                model_reset();
                repeat (2) @(negedge clk);
                rst_n   = 1'b1;
                tx_wait = 1'b0;
                elink_en = 1'b1;
                wr_wait = 1'b0;
                clear_cnt();
                step();
                check("midrst_regrant_rr", PW'(dut_cnt[0]), PW'(1));
            end
            rand_inputs();
            step();
        end

        for (int i = 0; i < 3; i++) req[i] = 1'b0;
        @(posedge clk);
        #2;
        check("sb_empty", PW'(sb_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
